// File: rtl/axis_pattern_gen_mc.sv
// AXI4-Stream test-pattern source: counter / LFSR32 / walking-one / constant patterns,
// runtime frame length, frame count and inter-frame gap, with a graceful end-of-frame stop.
module axis_pattern_gen_mc #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned GAP_WIDTH  = 8
) (
  input  logic                    m_axis_aclk,
  input  logic                    m_axis_aresetn,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              cfg_mode,
  input  logic [DATA_WIDTH-1:0]   cfg_seed,
  input  logic [CNT_WIDTH-1:0]    cfg_frame_beats,
  input  logic [CNT_WIDTH-1:0]    cfg_num_frames,
  input  logic [GAP_WIDTH-1:0]    cfg_gap,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    frames_sent
);

  localparam int unsigned Reps     = DATA_WIDTH / 32;
  localparam logic [31:0] LfsrMask = 32'h8020_0003;
  localparam logic [1:0]  ModeCnt  = 2'd0;
  localparam logic [1:0]  ModeLfsr = 2'd1;
  localparam logic [1:0]  ModeWalk = 2'd2;

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d, pat_next, pat_init;
  logic [CNT_WIDTH-1:0]  last_beat_q, last_beat_d, num_frames_q, num_frames_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d, frames_q, frames_d, frames_inc;
  logic [GAP_WIDTH-1:0]  gap_cfg_q, gap_cfg_d, gap_q, gap_d;
  logic                  stop_q, stop_d, done_q, done_d;
  logic [31:0]           lfsr_seed, lfsr_cur;
  logic                  at_last, stop_pend, run_over;

  assign at_last    = (beat_q == last_beat_q);
  assign frames_inc = frames_q + CNT_WIDTH'(1);
  // A stop seen in the same cycle as the tlast handshake already counts as pending.
  assign stop_pend  = stop_q | stop;
  assign run_over   = (num_frames_q != '0) && (frames_inc == num_frames_q);

  always_comb begin
    lfsr_seed = (cfg_seed[31:0] == 32'd0) ? 32'd1 : cfg_seed[31:0];
    pat_init  = cfg_seed;
    if (cfg_mode == ModeLfsr) begin
      pat_init       = '0;
      pat_init[31:0] = lfsr_seed;
    end else if (cfg_mode == ModeWalk) begin
      pat_init = DATA_WIDTH'(1);
    end
  end

  always_comb begin
    lfsr_cur = pat_q[31:0];
    pat_next = pat_q;
    case (mode_q)
      ModeCnt:  pat_next = pat_q + DATA_WIDTH'(1);
      ModeLfsr: begin
        pat_next       = '0;
        pat_next[31:0] = lfsr_cur[0] ? ((lfsr_cur >> 1) ^ LfsrMask) : (lfsr_cur >> 1);
      end
      ModeWalk: pat_next = {pat_q[DATA_WIDTH-2:0], pat_q[DATA_WIDTH-1]};
      default:  pat_next = pat_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    pat_d        = pat_q;
    last_beat_d  = last_beat_q;
    num_frames_d = num_frames_q;
    gap_cfg_d    = gap_cfg_q;
    beat_d       = beat_q;
    frames_d     = frames_q;
    gap_d        = gap_q;
    stop_d       = stop_q;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d      = StSend;
          mode_d       = cfg_mode;
          pat_d        = pat_init;
          last_beat_d  = (cfg_frame_beats == '0) ? '0 : cfg_frame_beats - CNT_WIDTH'(1);
          num_frames_d = cfg_num_frames;
          gap_cfg_d    = cfg_gap;
          beat_d       = '0;
          frames_d     = '0;
          gap_d        = '0;
        end
      end
      StSend: begin
        if (stop) stop_d = 1'b1;
        if (m_axis_tready) begin
          pat_d = pat_next;
          if (at_last) begin
            beat_d   = '0;
            frames_d = frames_inc;
            if (stop_pend || run_over) begin
              state_d = StIdle;
            end else if (gap_cfg_q != '0) begin
              state_d = StGap;
              gap_d   = '0;
            end
          end else begin
            beat_d = beat_q + CNT_WIDTH'(1);
          end
        end
      end
      StGap: begin
        if (stop) stop_d = 1'b1;
        if (stop_pend) begin
          state_d = StIdle;
        end else if (gap_q == gap_cfg_q - GAP_WIDTH'(1)) begin
          state_d = StSend;
        end else begin
          gap_d = gap_q + GAP_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StIdle) stop_d = 1'b0;
    done_d = (state_q != StIdle) && (state_d == StIdle);
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q      <= StIdle;
      mode_q       <= '0;
      pat_q        <= '0;
      last_beat_q  <= '0;
      num_frames_q <= '0;
      gap_cfg_q    <= '0;
      beat_q       <= '0;
      frames_q     <= '0;
      gap_q        <= '0;
      stop_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pat_q        <= pat_d;
      last_beat_q  <= last_beat_d;
      num_frames_q <= num_frames_d;
      gap_cfg_q    <= gap_cfg_d;
      beat_q       <= beat_d;
      frames_q     <= frames_d;
      gap_q        <= gap_d;
      stop_q       <= stop_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    m_axis_tvalid = (state_q == StSend);
    m_axis_tlast  = m_axis_tvalid && at_last;
    m_axis_tkeep  = {(DATA_WIDTH/8){m_axis_tvalid}};
    m_axis_tdata  = pat_q;
    if (mode_q == ModeLfsr) m_axis_tdata = {Reps{pat_q[31:0]}};
    busy          = (state_q != StIdle);
    done          = done_q;
    frames_sent   = frames_q;
  end

endmodule

// File: tb/tb_axis_pattern_gen_mc.sv
// Self-checking bench for axis_pattern_gen_mc: table-driven runs, corner sequences and
// randomized runs checked against a beat-list reference model.
module tb_axis_pattern_gen_mc;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;
  localparam int unsigned GW = 8;
  localparam int unsigned KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_seed;
  logic [CW-1:0] cfg_frame_beats, cfg_num_frames;
  logic [GW-1:0] cfg_gap;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [KW-1:0] m_axis_tkeep;
  logic          busy, done;
  logic [CW-1:0] frames_sent;

  axis_pattern_gen_mc #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW),
    .GAP_WIDTH (GW)
  ) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .start          (start),
    .stop           (stop),
    .cfg_mode       (cfg_mode),
    .cfg_seed       (cfg_seed),
    .cfg_frame_beats(cfg_frame_beats),
    .cfg_num_frames (cfg_num_frames),
    .cfg_gap        (cfg_gap),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tkeep   (m_axis_tkeep),
    .busy           (busy),
    .done           (done),
    .frames_sent    (frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] seed;
    int            fb;
    int            nf;
    int            gap;
    bit            rnd;
    int            stop_at;     // beat index (whole run) at which stop is raised; -1 = never
    int            exp_beats;   // -1 = only the model is used
    int            exp_frames;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
  } vec_t;

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_data[$];
  bit            exp_last_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rep32(input logic [31:0] s);
    logic [DW-1:0] r;
    for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = s;
    return r;
  endfunction

  // Reference: the list of beats a run must deliver, computed from the pattern rules.
  task automatic build_model(input vec_t v, output int nframes);
    int            fb;
    int            sf;
    logic [31:0]   s;
    logic [DW-1:0] d;
    exp_data.delete();
    exp_last_q.delete();
    fb      = (v.fb == 0) ? 1 : v.fb;
    nframes = v.nf;
    if (v.stop_at >= 0) begin
      sf = v.stop_at / fb + 1;
      if (v.nf == 0 || sf < v.nf) nframes = sf;
    end
    s = (v.seed[31:0] == 32'd0) ? 32'd1 : v.seed[31:0];
    for (int k = 0; k < nframes * fb; k++) begin
      case (v.mode)
        2'd0: d = v.seed + DW'(k);
        2'd1: begin
          d = rep32(s);
          s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        end
        2'd2: d = DW'(1) << (k % int'(DW));
        default: d = v.seed;
      endcase
      exp_data.push_back(d);
      exp_last_q.push_back((k % fb) == fb - 1);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm, input bit scramble);
    int            nframes;
    int            cyc = 0, stab_err = 0, keep_err = 0, gap_err = 0, bubble_err = 0;
    int            idle_run = 0, mism = 0, done_cnt = 0;
    bit            prev_v = 0, prev_hs = 0, after_last = 0, finished = 0;
    logic [DW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;
    logic [CW-1:0] fs_at_done = '0;
    logic          busy_at_done = 1'b1;
    logic [DW-1:0] cd[$];
    bit            cl[$];
    build_model(v, nframes);
    @(negedge clk);
    cfg_mode        = v.mode;
    cfg_seed        = v.seed;
    cfg_frame_beats = CW'(v.fb);
    cfg_num_frames  = CW'(v.nf);
    cfg_gap         = GW'(v.gap);
    start           = 1'b1;
    stop            = 1'b0;
    m_axis_tready   = v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, " first-beat latency"}, DW'(m_axis_tvalid), DW'(1));
    while (!finished && cyc < 4000) begin
      if (prev_v && !prev_hs &&
          (!m_axis_tvalid || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l)) stab_err++;
      if (m_axis_tkeep !== {KW{m_axis_tvalid}}) keep_err++;
      if (busy && !m_axis_tvalid && !after_last) bubble_err++;
      if (after_last && busy && !m_axis_tvalid) idle_run++;
      if (after_last && m_axis_tvalid) begin
        if (idle_run != v.gap) gap_err++;
        after_last = 0;
      end
      if (done) begin
        done_cnt++;
        finished     = 1;
        fs_at_done   = frames_sent;
        busy_at_done = busy;
      end else begin
        m_axis_tready = v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        stop          = 1'b0;
        start         = 1'b0;
        if (m_axis_tvalid && v.stop_at >= 0 && cd.size() == v.stop_at) begin
          m_axis_tready = 1'b1;
          stop          = 1'b1;
        end
        if (scramble && busy) begin
          start           = ($urandom_range(0, 3) == 0);
          cfg_mode        = 2'($urandom);
          cfg_seed        = {$urandom, $urandom};
          cfg_frame_beats = CW'($urandom);
          cfg_num_frames  = CW'($urandom);
          cfg_gap         = GW'($urandom);
        end
        prev_hs = m_axis_tvalid && m_axis_tready;
        prev_v  = m_axis_tvalid;
        prev_d  = m_axis_tdata;
        prev_l  = m_axis_tlast;
        if (prev_hs) begin
          cd.push_back(m_axis_tdata);
          cl.push_back(m_axis_tlast);
          if (m_axis_tlast) begin
            after_last = 1;
            idle_run   = 0;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    check({nm, " run completes with done"}, DW'(done_cnt), DW'(1));
    check({nm, " busy low with done"}, DW'(busy_at_done), DW'(0));
    check({nm, " frames_sent at done"}, DW'(fs_at_done), DW'(nframes));
    check({nm, " accepted beat count"}, DW'(cd.size()), DW'(exp_data.size()));
    for (int i = 0; i < cd.size() && i < exp_data.size(); i++)
      if (cd[i] !== exp_data[i] || cl[i] !== exp_last_q[i]) mism++;
    check({nm, " beat/tlast mismatches vs model"}, DW'(mism), DW'(0));
    check({nm, " held under backpressure"}, DW'(stab_err + bubble_err), DW'(0));
    check({nm, " tkeep"}, DW'(keep_err), DW'(0));
    check({nm, " gap cycles"}, DW'(gap_err), DW'(0));
    if (v.exp_beats >= 0) begin
      check({nm, " table beat count"}, DW'(cd.size()), DW'(v.exp_beats));
      check({nm, " table frames"}, DW'(fs_at_done), DW'(v.exp_frames));
      check({nm, " table first tdata"}, (cd.size() > 0) ? cd[0] : 'x, v.exp_first);
      check({nm, " table last tdata"}, (cd.size() > 0) ? cd[cd.size()-1] : 'x, v.exp_last);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " tvalid"}, DW'(m_axis_tvalid), DW'(0));
    check({nm, " tlast"}, DW'(m_axis_tlast), DW'(0));
    check({nm, " tdata"}, m_axis_tdata, DW'(0));
    check({nm, " tkeep"}, DW'(m_axis_tkeep), DW'(0));
    check({nm, " busy"}, DW'(busy), DW'(0));
    check({nm, " done"}, DW'(done), DW'(0));
    check({nm, " frames_sent"}, DW'(frames_sent), DW'(0));
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    tbl[0] = '{2'd0, 64'h10, 4, 2, 0, 1'b0, -1, 8, 2, 64'h10, 64'h17};
    tbl[1] = '{2'd0, 64'h10, 4, 2, 0, 1'b1, -1, 8, 2, 64'h10, 64'h17};
    tbl[2] = '{2'd1, 64'h0, 3, 1, 0, 1'b0, -1, 3, 1,
               64'h0000_0001_0000_0001, 64'hC030_0002_C030_0002};
    tbl[3] = '{2'd2, 64'h0, 40, 2, 5, 1'b1, -1, 80, 2, 64'h1, 64'h8000};
    tbl[4] = '{2'd0, 64'h100, 8, 0, 2, 1'b0, 11, 16, 2, 64'h100, 64'h10F};
    tbl[5] = '{2'd0, 64'h100, 2, 1, 0, 1'b1, -1, 2, 1, 64'h100, 64'h101};
    tbl[6] = '{2'd3, 64'hDEAD_BEEF_CAFE_F00D, 0, 3, 1, 1'b1, -1, 3, 3,
               64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D};
    tbl[7] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFE, 2, 2, 0, 1'b0, -1, 4, 2,
               64'hFFFF_FFFF_FFFF_FFFE, 64'h1};

    rst_n           = 1'b0;
    start           = 1'b0;
    stop            = 1'b0;
    cfg_mode        = '0;
    cfg_seed        = '0;
    cfg_frame_beats = '0;
    cfg_num_frames  = '0;
    cfg_gap         = '0;
    m_axis_tready   = 1'b0;
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i), 1'b0);

    // start together with stop in IDLE must not begin a run
    @(negedge clk);
    cfg_mode = 2'd0; cfg_seed = 64'h5; cfg_frame_beats = 16'd4; cfg_num_frames = 16'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start+stop busy", DW'(busy), DW'(0));
    check("start+stop tvalid", DW'(m_axis_tvalid), DW'(0));

    // reset in the middle of a frame
    @(negedge clk);
    cfg_mode = 2'd0; cfg_seed = 64'h55; cfg_frame_beats = 16'd8; cfg_num_frames = 16'd1;
    cfg_gap = '0; m_axis_tready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid-frame beat 2 tdata", m_axis_tdata, 64'h57);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    rv = '{2'd0, 64'h55, 3, 1, 0, 1'b0, -1, 3, 1, 64'h55, 64'h57};
    run_vec(rv, "after reset", 1'b0);

    // randomized runs with scrambled cfg/start while busy
    for (int r = 0; r < 10; r++) begin
      rv.mode      = 2'($urandom);
      rv.seed      = {$urandom, $urandom};
      rv.fb        = int'($urandom_range(0, 12));
      rv.nf        = int'($urandom_range(0, 3));
      rv.gap       = int'($urandom_range(0, 4));
      rv.rnd       = 1'b1;
      rv.exp_beats = -1;
      if (rv.nf == 0)
        rv.stop_at = int'($urandom_range(0, 3 * ((rv.fb == 0) ? 1 : rv.fb) - 1));
      else if ($urandom_range(0, 1) == 1)
        rv.stop_at = int'($urandom_range(0, rv.nf * ((rv.fb == 0) ? 1 : rv.fb) - 1));
      else
        rv.stop_at = -1;
      run_vec(rv, $sformatf("rand%0d", r), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_pattern_gen_mc.md
Name: axis_pattern_gen_mc

Overview:
Parametrised AXI4-Stream test-pattern source, the successor to the fixed 32-bit counter generator. It adds selectable pattern modes, a runtime frame length and frame count, inter-frame gaps, and a clean stop. It is fully AXI4-Stream compliant: data is held stable under backpressure. It feeds the DMA S2MM path for throughput and integrity testing, with config and start/stop driven from PS GPIO/registers.

Parameters:
DATA_WIDTH, 32, tdata width; must be 32, 64 or 128.
CNT_WIDTH, 16, width of frame-length, frame-count and frames_sent fields.
GAP_WIDTH, 8, width of the inter-frame gap field.

Ports:
m_axis_aclk  in  1  stream clock
m_axis_aresetn  in  1  reset, asynchronous assert, active-low
start  in  1  level/pulse; begins a run when sampled high in IDLE
stop  in  1  request graceful stop at the end of the current frame
cfg_mode  in  2  0=counter, 1=LFSR32, 2=walking-one, 3=constant
cfg_seed  in  DATA_WIDTH  initial value (counter/constant); low 32 bits seed the LFSR
cfg_frame_beats  in  CNT_WIDTH  beats per frame; 0 treated as 1
cfg_num_frames  in  CNT_WIDTH  frames per run; 0 = continuous until stop
cfg_gap  in  GAP_WIDTH  idle cycles (tvalid=0) after each tlast beat
m_axis_tdata  out  DATA_WIDTH  pattern data
m_axis_tvalid  out  1  valid
m_axis_tready  in  1  ready
m_axis_tlast  out  1  last beat of frame
m_axis_tkeep  out  DATA_WIDTH/8  all ones while tvalid, else 0
busy  out  1  high in SEND or GAP
done  out  1  one-cycle pulse on the return to IDLE
frames_sent  out  CNT_WIDTH  frames completed in the current/last run; wraps; cleared on start

Behaviour:
- Reset: all outputs 0, state IDLE, internal pattern/beat/gap counters 0.
- States:
  - IDLE -> SEND when start=1 and stop=0. All cfg_* inputs are latched on that edge; cfg changes while busy are ignored.
  - SEND -> GAP on tlast handshake if the run continues and gap>0. SEND -> SEND (back-to-back, no bubble) if gap=0.
  - SEND -> IDLE on tlast handshake when frames_sent+1 == num_frames (num_frames≠0), or when a stop is pending.
  - GAP -> SEND after exactly cfg_gap cycles. GAP -> IDLE immediately if stop is pending.
- Latency: first beat has tvalid=1 in the cycle after start is sampled.
- Handshake:
  - tdata, tlast and tkeep change only after a beat is accepted (tvalid&tready).
  - tvalid never drops in SEND without acceptance.
  - tvalid does not depend combinationally on tready.
- Beat/tlast: beat counter counts 0..frame_beats-1; tlast=1 on beat frame_beats-1. With frame_beats=1, every beat has tlast.
- Pattern state advances once per accepted beat and carries across frames; it restarts only on a new start.
  - Counter: first beat = seed; then +1 modulo 2^DATA_WIDTH (wraps to 0).
  - LFSR32: Galois right-shift, mask 0x80200003. If lsb=1, s=(s>>1)^mask; else s>>1. A seed of 0 is replaced by 1. First beat = seed. tdata = s replicated DATA_WIDTH/32 times.
  - Walking-one: first beat = 1 (bit 0); rotate left by one; wraps to bit 0 after DATA_WIDTH beats.
  - Constant: every beat = seed.
- stop:
  - Sticky once sampled while busy; cleared on the return to IDLE.
  - The current frame always completes with tlast.
  - stop in IDLE has no effect. start+stop in the same IDLE cycle: no run.
- start while busy is ignored.
- done pulses one cycle in the first IDLE cycle after SEND/GAP. busy falls in that same cycle.
- frames_sent increments on each tlast handshake.
- Reset mid-frame: outputs drop to 0 asynchronously; no partial-frame completion; state IDLE.

Test Plan:
- Counter, seed 0x10, frame_beats 4, num_frames 2, gap 0, tready=1 -> tdata 0x10..0x17, tlast on 0x13 and 0x17, no bubbles, done pulse, frames_sent=2, busy low.
- Same config, tready toggled pseudo-randomly -> tdata/tlast stable while tvalid&!tready, identical accepted sequence, tvalid never drops mid-run.
- LFSR, seed 0, DATA_WIDTH 64, frame_beats 3, num_frames 1 -> beats 0x00000001_00000001, 0x80200003_80200003, 0xC0300002_C0300002, tlast on the third.
- Walking-one, frame_beats 40, gap 5, num_frames 2, DATA_WIDTH 32 -> beat 32 wraps to 0x1, exactly 5 tvalid=0 cycles between frames.
- Continuous counter (num_frames 0), frame_beats 8, stop asserted at beat 3 of frame 2 -> frame 2 completes to beat 7 with tlast, then IDLE, done, frames_sent=2; a second start restarts tdata at the seed.
- Reset asserted at beat 2 of a frame -> all outputs 0 immediately. After release plus start, the first beat = seed and frames_sent=0.
